// File: rtl/fetch_prefetch_unit.sv
// Fetch stage: PC generator feeding a DEPTH-entry in-order prefetch queue over a
// request/grant + in-order response instruction memory, with redirect and stale-response discard.
module fetch_prefetch_unit #(
   parameter int                XLEN      = 32,
   parameter int                ILEN      = 32,
   parameter int                DEPTH     = 4,
   parameter logic [XLEN-1:0]   RESET_PC  = '0,
   parameter int                PC_STEP   = 4,
   parameter logic [ILEN-1:0]   NOP_INSTR = 32'hE1A00000
) (
   input  logic                       CLK,
   input  logic                       ResetN,
   output logic                       IMemReq,
   output logic [XLEN-1:0]            PCF,
   input  logic                       IMemGnt,
   input  logic                       IMemRValid,
   input  logic [ILEN-1:0]            IMemRData,
   input  logic                       StallD,
   input  logic                       BranchTakenE,
   input  logic [XLEN-1:0]            BranchTargetE,
   output logic                       ValidD,
   output logic [ILEN-1:0]            InstrD,
   output logic [XLEN-1:0]            PCD,
   output logic [$clog2(DEPTH+1)-1:0] Occupancy
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   logic [XLEN-1:0]  pc_q    [DEPTH];
   logic [ILEN-1:0]  instr_q [DEPTH];
   logic [DEPTH-1:0] filled_q, filled_d;
   logic [PW-1:0]    head_q, head_d, tail_q, tail_d, fill_q, fill_d;
   logic [CW-1:0]    occ_q, occ_d, outst_q, outst_d, disc_q, disc_d;
   logic [XLEN-1:0]  pcf_q, pcf_d, pcd_hold_q, pcd_hold_d;

   logic pop_raw, pop, issue, fill_en, drop, rsp_any;
   logic [CW:0] occ_after_pop, inflight;

   assign ValidD    = (occ_q != '0) && filled_q[head_q];
   assign InstrD    = ValidD ? instr_q[head_q] : NOP_INSTR;
   assign PCD       = ValidD ? pc_q[head_q] : pcd_hold_q;
   assign PCF       = pcf_q;
   assign Occupancy = occ_q;

   // A same-cycle pop frees its slot for the request issued in that cycle.
   assign pop_raw       = ValidD && !StallD;
   assign pop           = pop_raw && !BranchTakenE;
   assign occ_after_pop = {1'b0, occ_q} - {{CW{1'b0}}, pop_raw};
   assign inflight      = {1'b0, outst_q} + {1'b0, disc_q};
   assign IMemReq       = ResetN && !BranchTakenE && (occ_after_pop < DEPTH_C) && (inflight < DEPTH_C);
   assign issue         = IMemReq && IMemGnt;

   assign rsp_any = IMemRValid && ((disc_q != '0) || (outst_q != '0));
   assign drop    = IMemRValid && (disc_q != '0) && !BranchTakenE;
   assign fill_en = IMemRValid && (disc_q == '0) && (outst_q != '0) && !BranchTakenE;

   always_comb begin
      pcf_d      = pcf_q;
      head_d     = head_q;
      tail_d     = tail_q;
      fill_d     = fill_q;
      filled_d   = filled_q;
      occ_d      = occ_q;
      outst_d    = outst_q;
      disc_d     = disc_q;
      pcd_hold_d = pcd_hold_q;
      if (ValidD)
         pcd_hold_d = pc_q[head_q];
      if (BranchTakenE) begin
         // Everything still in flight becomes stale; a response landing now is already one of them.
         pcf_d    = {BranchTargetE[XLEN-1:2], 2'b00};
         head_d   = '0;
         tail_d   = '0;
         fill_d   = '0;
         filled_d = '0;
         occ_d    = '0;
         outst_d  = '0;
         disc_d   = disc_q + outst_q - CW'(rsp_any);
      end else begin
         if (issue) begin
            tail_d = tail_q + PW'(1);
            pcf_d  = pcf_q + XLEN'(PC_STEP);
         end
         if (fill_en) begin
            filled_d[fill_q] = 1'b1;
            fill_d           = fill_q + PW'(1);
         end
         if (drop)
            disc_d = disc_q - CW'(1);
         if (pop) begin
            filled_d[head_q] = 1'b0;
            head_d           = head_q + PW'(1);
         end
         occ_d   = occ_q + CW'(issue) - CW'(pop);
         outst_d = outst_q + CW'(issue) - CW'(fill_en);
      end
   end

   always_ff @(posedge CLK or negedge ResetN) begin
      if (!ResetN) begin
         pcf_q      <= RESET_PC;
         head_q     <= '0;
         tail_q     <= '0;
         fill_q     <= '0;
         filled_q   <= '0;
         occ_q      <= '0;
         outst_q    <= '0;
         disc_q     <= '0;
         pcd_hold_q <= '0;
      end else begin
         pcf_q      <= pcf_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         fill_q     <= fill_d;
         filled_q   <= filled_d;
         occ_q      <= occ_d;
         outst_q    <= outst_d;
         disc_q     <= disc_d;
         pcd_hold_q <= pcd_hold_d;
      end
   end

   // Payload storage needs no reset: it is only observed through filled entries.
   always_ff @(posedge CLK) begin
      if (issue)
         pc_q[tail_q] <= pcf_q;
      if (fill_en)
         instr_q[fill_q] <= IMemRData;
   end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: in-order variable-latency memory plus a queue-level
// reference model of the delivered instruction stream.
module tb_fetch_prefetch_unit;
   localparam int          DEPTH = 4;
   localparam logic [31:0] NOP   = 32'hE1A00000;

   logic        CLK = 1'b0;
   logic        ResetN;
   logic        IMemReq, IMemGnt, IMemRValid, StallD, BranchTakenE, ValidD;
   logic [31:0] PCF, IMemRData, BranchTargetE, InstrD, PCD;
   logic [2:0]  Occupancy;

   fetch_prefetch_unit #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0),
                         .PC_STEP(4), .NOP_INSTR(NOP)) dut (
      .CLK(CLK), .ResetN(ResetN), .IMemReq(IMemReq), .PCF(PCF), .IMemGnt(IMemGnt),
      .IMemRValid(IMemRValid), .IMemRData(IMemRData), .StallD(StallD),
      .BranchTakenE(BranchTakenE), .BranchTargetE(BranchTargetE), .ValidD(ValidD),
      .InstrD(InstrD), .PCD(PCD), .Occupancy(Occupancy)
   );

   always #5 CLK = ~CLK;

   typedef struct { logic [31:0] addr; int ready; } req_t;
   req_t        memq[$];
   logic [31:0] mq[$];
   int          cyc, lat_min, lat_max, last_ready;
   int          m_outst, m_disc;
   logic [31:0] m_pc, m_last_pcd;
   int          vectors, miscompares;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      memq.delete();
      m_outst    = 0;
      m_disc     = 0;
      m_pc       = 32'h0;
      m_last_pcd = 32'h0;
      last_ready = 0;
   endtask

   // Asserts reset away from the clock edge, checks reset values at once, releases after two edges.
   task automatic do_reset();
      #2 ResetN = 1'b0;
      IMemRValid   = 1'b0;
      BranchTakenE = 1'b0;
      #1;
      chk("rst_req",   64'(IMemReq),   64'(0));
      chk("rst_valid", 64'(ValidD),    64'(0));
      chk("rst_instr", 64'(InstrD),    64'(NOP));
      chk("rst_pcd",   64'(PCD),       64'(0));
      chk("rst_occ",   64'(Occupancy), 64'(0));
      chk("rst_pcf",   64'(PCF),       64'(0));
      $display("reset applied at cycle %0d", cyc);
      model_reset();
      @(posedge CLK);
      @(posedge CLK);
      cyc++;
      #1 ResetN = 1'b1;
   endtask

   task automatic cycle(input bit stall, input bit gnt, input bit br, input logic [31:0] tgt);
      bit valid_m, pop_m, req_m, rv;
      int r;
      StallD        = stall;
      IMemGnt       = gnt;
      BranchTakenE  = br;
      BranchTargetE = tgt;
      rv            = (memq.size() > 0) && (memq[0].ready <= cyc);
      IMemRValid    = rv;
      IMemRData     = rv ? mem_word(memq[0].addr) : $urandom;
      #1;
      // Issued-but-unanswered requests are always the youngest queue entries.
      valid_m = mq.size() > m_outst;
      pop_m   = valid_m && !stall;
      req_m   = !br && ((mq.size() - int'(pop_m)) < DEPTH) && ((m_outst + m_disc) < DEPTH);
      chk("req",   64'(IMemReq),   64'(req_m));
      if (req_m) chk("pcf", 64'(PCF), 64'(m_pc));
      chk("valid", 64'(ValidD),    64'(valid_m));
      chk("occ",   64'(Occupancy), 64'(mq.size()));
      if (valid_m) begin
         chk("pcd",   64'(PCD),    64'(mq[0]));
         chk("instr", 64'(InstrD), 64'(mem_word(mq[0])));
      end else begin
         chk("pcd_hold", 64'(PCD),    64'(m_last_pcd));
         chk("nop",      64'(InstrD), 64'(NOP));
      end
      $display("cyc %0d stall=%0b gnt=%0b br=%0b rv=%0b | req=%0b pcf=%h valid=%0b pcd=%h occ=%0d",
               cyc, stall, gnt, br, rv, IMemReq, PCF, ValidD, PCD, Occupancy);
      if (IMemReq && gnt) begin
         r = cyc + $urandom_range(lat_max, lat_min);
         if (r <= last_ready) r = last_ready + 1;
         last_ready = r;
         memq.push_back('{PCF, r});
      end
      if (rv) void'(memq.pop_front());
      if (valid_m) m_last_pcd = mq[0];
      if (br) begin
         mq.delete();
         if (rv && (m_disc + m_outst) > 0) m_disc = m_disc + m_outst - 1;
         else m_disc = m_disc + m_outst;
         m_outst = 0;
         m_pc    = {tgt[31:2], 2'b00};
      end else begin
         if (rv) begin
            if (m_disc > 0) m_disc--;
            else if (m_outst > 0) m_outst--;
         end
         if (pop_m) void'(mq.pop_front());
         if (req_m && gnt) begin
            mq.push_back(m_pc);
            m_pc = m_pc + 32'd4;
            m_outst++;
         end
      end
      @(posedge CLK);
      cyc++;
      #1;
   endtask

   initial begin
      ResetN = 1'b1; StallD = 1'b0; IMemGnt = 1'b1; IMemRValid = 1'b0; IMemRData = '0;
      BranchTakenE = 1'b0; BranchTargetE = '0;
      vectors = 0; miscompares = 0; cyc = 0; lat_min = 1; lat_max = 1;
      model_reset();
      @(posedge CLK); #1;

      // Streaming from reset with single-cycle memory
      do_reset();
      repeat (20) cycle(0, 1, 0, 0);

      // Decode stalled long enough to fill the queue
      do_reset();
      repeat (10) cycle(1, 1, 0, 0);
      chk("full_pcf", 64'(PCF),       64'(32'h10));
      chk("full_occ", 64'(Occupancy), 64'(DEPTH));
      chk("full_req", 64'(IMemReq),   64'(0));
      repeat (10) cycle(0, 1, 0, 0);

      // Grant withheld at PCF=0x8
      do_reset();
      repeat (2) cycle(0, 1, 0, 0);
      repeat (3) cycle(0, 0, 0, 0);
      chk("gnt_hold_pcf", 64'(PCF), 64'(32'h8));
      repeat (8) cycle(0, 1, 0, 0);

      // Redirect with three requests in flight on slow memory
      do_reset();
      lat_min = 4; lat_max = 4;
      repeat (3) cycle(0, 1, 0, 0);
      cycle(0, 1, 1, 32'h103);
      chk("redir_pcf", 64'(PCF), 64'(32'h100));
      repeat (16) cycle(0, 1, 0, 0);

      // Redirect coinciding with a response and a pop
      do_reset();
      lat_min = 1; lat_max = 1;
      repeat (5) cycle(0, 1, 0, 0);
      cycle(0, 1, 1, 32'h2000);
      chk("same_cyc_valid", 64'(ValidD), 64'(0));
      repeat (6) cycle(0, 1, 0, 0);

      // PC wrap past the top of the address space
      cycle(0, 1, 1, 32'hFFFF_FFF6);
      repeat (10) cycle(0, 1, 0, 0);

      // Asynchronous reset in mid-stream, then restart
      do_reset();
      repeat (8) cycle(0, 1, 0, 0);

      // Random traffic
      lat_min = 1; lat_max = 4;
      repeat (1500) cycle($urandom_range(9) < 3, $urandom_range(9) < 7,
                          $urandom_range(99) < 3, $urandom);
      do_reset();
      repeat (6) cycle(0, 1, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
